// File: rtl/mem_port_arbiter_if.sv
// Request/grant and memory-bus bundle for mem_port_arbiter.
// master: requesters plus memory; slave: the arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  if_gnt, if_rdata,
    input  d_gnt, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output if_gnt, if_rdata,
    output d_gnt, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (D).
// MEM_ARB_ROUND_ROBIN_EN: round-robin on ties; otherwise D has fixed priority.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  state_t     state;
  logic [3:0] cnt;
  logic       owner_d;
  logic       pick_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic       last_d;

  // On a tie the requester not served last wins.
  always_comb begin
    pick_d = bus.d_req & (~bus.if_req | ~last_d);
  end
`else
  always_comb begin
    pick_d = bus.d_req;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      owner_d       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d        <= 1'b1;
`endif
      bus.if_gnt    <= 1'b0;
      bus.d_gnt     <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.if_gnt <= 1'b0;
      bus.d_gnt  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.if_req | bus.d_req) begin
            state         <= ACCESS;
            owner_d       <= pick_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d        <= pick_d;
`endif
            cnt           <= CNT_INIT;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= pick_d & bus.d_we;
            bus.mem_addr  <= pick_d ? bus.d_addr : bus.if_addr;
            bus.mem_wdata <= pick_d ? bus.d_wdata : '0;
            bus.busy      <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state      <= DONE;
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            if (owner_d) begin
              bus.d_gnt <= 1'b1;
              if (!bus.mem_we)
                bus.d_rdata <= bus.mem_rdata;
            end else begin
              bus.if_gnt   <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a transaction model.
// Three instances cover WAIT_CYCLES of 1, 0 and 15.
module tb_mem_port_arbiter;

  localparam int W1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus1 ();
  mem_port_arbiter_if bus0 ();
  mem_port_arbiter_if bus15 ();

  mem_port_arbiter #(.WAIT_CYCLES(W1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  mem_port_arbiter #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  mem_port_arbiter #(.WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .rst(rst), .bus(bus15)
  );

  int checks = 0;
  int errors = 0;

  // Environment memory and the model's own copy of it.
  logic [31:0] phys_mem [16];
  logic [31:0] ref_mem  [16];
  bit          mem_init = 1'b1;
  bit          ovr_en   = 1'b0;
  logic [31:0] ovr_val  = '0;
  bit          last_d   = 1'b1;

  function automatic logic [31:0] init_word(int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  assign bus1.mem_rdata  = ovr_en ? ovr_val : phys_mem[bus1.mem_addr[5:2]];
  assign bus0.mem_rdata  = 32'h0000_0A0A;
  assign bus15.mem_rdata = 32'h0000_F0F0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) phys_mem[i] <= init_word(i);
    end else if (bus1.mem_en && bus1.mem_we) begin
      phys_mem[bus1.mem_addr[5:2]] <= bus1.mem_wdata;
    end
  end

  function automatic bit pick_d(bit ir, bit dr);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return (ir && dr) ? !last_d : dr;
`else
    return dr;
`endif
  endfunction

  task automatic idle_inputs;
    bus1.if_req = 0; bus1.if_addr = '0;
    bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0;
    bus0.if_req = 0; bus0.if_addr = '0;
    bus0.d_req = 0; bus0.d_we = 0; bus0.d_addr = '0; bus0.d_wdata = '0;
    bus15.if_req = 0; bus15.if_addr = '0;
    bus15.d_req = 0; bus15.d_we = 0; bus15.d_addr = '0; bus15.d_wdata = '0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_d = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    v = {28'h0, bus1.if_gnt, bus1.d_gnt, bus1.mem_en, bus1.mem_we};
    checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL reset_ctrl got %0h exp 0", v);
    end
    checks++;
    if (bus1.mem_addr !== '0 || bus1.mem_wdata !== '0) begin
      errors++; $display("FAIL reset_bus got %0h/%0h exp 0/0", bus1.mem_addr, bus1.mem_wdata);
    end
    checks++;
    if (bus1.if_rdata !== '0 || bus1.d_rdata !== '0) begin
      errors++; $display("FAIL reset_rdata got %0h/%0h exp 0/0", bus1.if_rdata, bus1.d_rdata);
    end
    checks++;
    if ({bus1.busy, bus0.busy, bus15.busy} !== 3'b000) begin
      errors++; $display("FAIL reset_busy got %b exp 000", {bus1.busy, bus0.busy, bus15.busy});
    end
    rst = 1'b0;
    last_d = 1'b1;
  endtask

  task automatic test_fetch;
    int en_cnt = 0, busy_cnt = 0, gnt_at = -1, gnt_cnt = 0, bad = 0;
    bus1.if_req = 1; bus1.if_addr = 32'h40;
    ovr_en = 1; ovr_val = 32'hDEADBEEF;
    last_d = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (bus1.mem_en) begin
        en_cnt++;
        if (bus1.mem_addr !== 32'h40) bad++;
      end
      if (bus1.busy) busy_cnt++;
      if (bus1.d_gnt) bad++;
      if (bus1.if_gnt) begin
        gnt_cnt++;
        if (gnt_at < 0) gnt_at = n;
        bus1.if_req = 0;
      end
    end
    ovr_en = 0;
    checks++;
    if (en_cnt != W1 + 1 || bad != 0) begin
      errors++; $display("FAIL fetch_mem_en got %0d bad %0d exp %0d", en_cnt, bad, W1 + 1);
    end
    checks++;
    if (gnt_at != W1 + 2 || gnt_cnt != 1) begin
      errors++; $display("FAIL fetch_gnt got at %0d x%0d exp at %0d x1", gnt_at, gnt_cnt, W1 + 2);
    end
    checks++;
    if (bus1.if_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL fetch_rdata got %0h exp deadbeef", bus1.if_rdata);
    end
    checks++;
    if (busy_cnt != W1 + 2) begin
      errors++; $display("FAIL fetch_busy got %0d exp %0d", busy_cnt, W1 + 2);
    end
  endtask

  task automatic test_store;
    int en_cnt = 0, we_cnt = 0, gnt_cnt = 0, bad = 0;
    logic [31:0] d_old = bus1.d_rdata;
    bus1.d_req = 1; bus1.d_we = 1;
    bus1.d_addr = 32'h100; bus1.d_wdata = 32'h12345678;
    last_d = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (bus1.mem_en) begin
        en_cnt++;
        if (bus1.mem_we) we_cnt++;
        if (bus1.mem_addr !== 32'h100 || bus1.mem_wdata !== 32'h12345678) bad++;
      end
      if (bus1.if_gnt) bad++;
      if (bus1.d_gnt) begin
        gnt_cnt++;
        bus1.d_req = 0; bus1.d_we = 0;
      end
    end
    ref_mem[0] = 32'h12345678;
    checks++;
    if (we_cnt != W1 + 1 || en_cnt != W1 + 1 || bad != 0) begin
      errors++; $display("FAIL store_we got %0d/%0d bad %0d exp %0d", we_cnt, en_cnt, bad, W1 + 1);
    end
    checks++;
    if (gnt_cnt != 1) begin
      errors++; $display("FAIL store_gnt got %0d exp 1", gnt_cnt);
    end
    checks++;
    if (bus1.d_rdata !== d_old) begin
      errors++; $display("FAIL store_rdata got %0h exp %0h", bus1.d_rdata, d_old);
    end
  endtask

  task automatic test_addr_change;
    int ok_cnt = 0, gnt_cnt = 0;
    do_reset();
    bus1.if_req = 1; bus1.if_addr = 32'h10;
    last_d = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) bus1.if_addr = 32'h20;
      if (bus1.mem_en && bus1.mem_addr === 32'h10) ok_cnt++;
      if (bus1.if_gnt) begin
        gnt_cnt++;
        bus1.if_req = 0;
      end
    end
    checks++;
    if (ok_cnt != W1 + 1 || gnt_cnt != 1) begin
      errors++; $display("FAIL addr_hold got %0d gnt %0d exp %0d gnt 1", ok_cnt, gnt_cnt, W1 + 1);
    end
    checks++;
    if (bus1.if_rdata !== ref_mem[4]) begin
      errors++; $display("FAIL addr_rdata got %0h exp %0h", bus1.if_rdata, ref_mem[4]);
    end
  endtask

  task automatic test_reset_mid;
    int en_cnt = 0, gnt_at = -1;
    logic [31:0] v;
    do_reset();
    bus1.if_req = 1; bus1.if_addr = 32'h8;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    v = {27'h0, bus1.if_gnt, bus1.d_gnt, bus1.mem_en, bus1.mem_we, bus1.busy};
    checks++;
    if (v !== 32'h0 || bus1.mem_addr !== '0 || bus1.if_rdata !== '0) begin
      errors++; $display("FAIL rstmid_now got %0h addr %0h exp 0", v, bus1.mem_addr);
    end
    @(negedge clk);
    checks++;
    if (bus1.if_gnt !== 1'b0 || bus1.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_hold got gnt %b busy %b exp 0 0", bus1.if_gnt, bus1.busy);
    end
    rst = 1'b0;
    last_d = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus1.mem_en) en_cnt++;
      if (bus1.if_gnt && gnt_at < 0) begin
        gnt_at = n;
        bus1.if_req = 0;
      end
    end
    checks++;
    if (gnt_at != W1 + 2 || en_cnt != W1 + 1) begin
      errors++; $display("FAIL rstmid_restart got at %0d en %0d exp %0d en %0d", gnt_at, en_cnt, W1 + 2, W1 + 1);
    end
    checks++;
    if (bus1.if_rdata !== ref_mem[2]) begin
      errors++; $display("FAIL rstmid_rdata got %0h exp %0h", bus1.if_rdata, ref_mem[2]);
    end
  endtask

  task automatic test_priority;
    bit got[$];
    bit exp_d;
    int both = 0;
    do_reset();
    bus1.if_req = 1; bus1.if_addr = 32'h14;
    bus1.d_req = 1; bus1.d_addr = 32'h18; bus1.d_we = 0;
    for (int n = 0; n < 40 && got.size() < 4; n++) begin
      @(negedge clk);
      if (bus1.if_gnt && bus1.d_gnt) both++;
      else if (bus1.if_gnt) got.push_back(1'b0);
      else if (bus1.d_gnt) got.push_back(1'b1);
    end
    bus1.if_req = 0; bus1.d_req = 0;
    checks++;
    if (got.size() != 4 || both != 0) begin
      errors++; $display("FAIL prio_count got %0d both %0d exp 4 both 0", got.size(), both);
    end
    for (int i = 0; i < got.size(); i++) begin
      exp_d = pick_d(1'b1, 1'b1);
      last_d = exp_d;
      checks++;
      if (got[i] !== exp_d) begin
        errors++; $display("FAIL prio_seq%0d got d=%b exp d=%b", i, got[i], exp_d);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_latency;
    int en0 = 0, en15 = 0, lat0 = -1, lat15 = -1;
    do_reset();
    bus0.if_req = 1; bus0.if_addr = 32'h4;
    bus15.d_req = 1; bus15.d_addr = 32'h8; bus15.d_we = 0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (bus0.mem_en) en0++;
      if (bus15.mem_en) en15++;
      if (bus0.if_gnt && lat0 < 0) begin lat0 = n; bus0.if_req = 0; end
      if (bus15.d_gnt && lat15 < 0) begin lat15 = n; bus15.d_req = 0; end
    end
    checks++;
    if (en0 != 1 || lat0 != 2) begin
      errors++; $display("FAIL w0_timing got en %0d lat %0d exp en 1 lat 2", en0, lat0);
    end
    checks++;
    if (en15 != 16 || lat15 != 17) begin
      errors++; $display("FAIL w15_timing got en %0d lat %0d exp en 16 lat 17", en15, lat15);
    end
    checks++;
    if (bus0.if_rdata !== 32'h0A0A || bus15.d_rdata !== 32'hF0F0) begin
      errors++; $display("FAIL wx_rdata got %0h/%0h exp a0a/f0f0", bus0.if_rdata, bus15.d_rdata);
    end
  endtask

  task automatic test_random;
    bit if_p = 0, d_p = 0, d_we_r = 0, win, we;
    logic [31:0] if_a = '0, d_a = '0, d_wd = '0, addr, wd;
    logic [31:0] exp_if = '0, exp_d = '0;
    int en_cnt, bad, lose;
    logic gnt_win;
    do_reset();
    for (int t = 0; t < 60; t++) begin
      if (!if_p && $urandom_range(0, 1) == 1) begin
        if_p = 1; if_a = $urandom() & 32'h0000_0FFC;
      end
      if (!d_p && $urandom_range(0, 1) == 1) begin
        d_p = 1; d_a = $urandom() & 32'h0000_0FFC;
        d_wd = $urandom(); d_we_r = 1'($urandom_range(0, 1));
      end
      if (!if_p && !d_p) begin
        if_p = 1; if_a = $urandom() & 32'h0000_0FFC;
      end
      bus1.if_req = if_p; bus1.if_addr = if_a;
      bus1.d_req = d_p; bus1.d_addr = d_a;
      bus1.d_we = d_we_r; bus1.d_wdata = d_wd;
      win = pick_d(if_p, d_p);
      last_d = win;
      addr = win ? d_a : if_a;
      we = win & d_we_r;
      wd = win ? d_wd : '0;
      en_cnt = 0; bad = 0; lose = 0; gnt_win = 1'b0;
      for (int n = 1; n <= W1 + 2; n++) begin
        @(negedge clk);
        if (bus1.mem_en) begin
          en_cnt++;
          if (bus1.mem_addr !== addr || bus1.mem_we !== we) bad++;
          if (we && bus1.mem_wdata !== wd) bad++;
        end
        if ((win ? bus1.if_gnt : bus1.d_gnt) !== 1'b0) lose++;
        if (n < W1 + 2 && (win ? bus1.d_gnt : bus1.if_gnt) !== 1'b0) lose++;
        if (n == W1 + 2) gnt_win = win ? bus1.d_gnt : bus1.if_gnt;
        if (n == 1) begin
          if (win) begin
            bus1.d_addr = $urandom(); bus1.d_wdata = $urandom(); bus1.d_we = ~d_we_r;
          end else begin
            bus1.if_addr = $urandom();
          end
        end
      end
      if (win && we) ref_mem[addr[5:2]] = wd;
      else if (win) exp_d = ref_mem[addr[5:2]];
      else exp_if = ref_mem[addr[5:2]];
      checks++;
      if (en_cnt != W1 + 1 || bad != 0) begin
        errors++; $display("FAIL rnd%0d_access got en %0d bad %0d exp en %0d", t, en_cnt, bad, W1 + 1);
      end
      checks++;
      if (gnt_win !== 1'b1 || lose != 0) begin
        errors++; $display("FAIL rnd%0d_gnt got %b stray %0d exp 1 stray 0 (d=%b)", t, gnt_win, lose, win);
      end
      checks++;
      if (bus1.if_rdata !== exp_if || bus1.d_rdata !== exp_d) begin
        errors++; $display("FAIL rnd%0d_rdata got %0h/%0h exp %0h/%0h", t, bus1.if_rdata, bus1.d_rdata, exp_if, exp_d);
      end
      if (win) begin d_p = 0; bus1.d_req = 0; end
      else begin if_p = 0; bus1.if_req = 0; end
      @(negedge clk);
      checks++;
      if (bus1.busy !== 1'b0 || bus1.mem_en !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_idle got busy %b en %b exp 0 0", t, bus1.busy, bus1.mem_en);
      end
    end
    bus1.if_req = 0; bus1.d_req = 0;
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    @(negedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    test_reset();
    test_fetch();
    test_store();
    test_addr_change();
    test_reset_mid();
    test_priority();
    test_latency();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single-port memory in the CPU and shares it between two requesters: instruction fetch (IF) and the load/store stage (D). Each request is latched and presented to memory for a programmable number of wait cycles, then completed with a one-cycle grant pulse and registered read data. The block sits between the CPU core's fetch and memory stages and the unified memory, under the top-level `MAIN` clock.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `WAIT_CYCLES`, 1, extra memory-access cycles beyond the first (legal 0..15)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `if_req`  in  1  fetch request, held until `if_gnt`
- `if_addr`  in  AW  fetch address
- `if_gnt`  out  1  fetch complete, one-cycle pulse
- `if_rdata`  out  DW  fetched word, valid while `if_gnt`=1
- `d_req`  in  1  load/store request, held until `d_gnt`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_gnt`  out  1  data access complete, one-cycle pulse
- `d_rdata`  out  DW  load data, valid while `d_gnt`=1
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, sampled on the last ACCESS cycle
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if either request is high, select the owner (see Configuration). Latch owner, address, we and wdata into registers, load `cnt`=`WAIT_CYCLES`, then go to ACCESS. IF requests latch we=0.
- ACCESS: drive `mem_en`=1, and drive `mem_we`, `mem_addr` and `mem_wdata` from the latched registers.
  - While `cnt`≠0: decrement `cnt`.
  - When `cnt`=0: capture `mem_rdata` into the owner's rdata register (loads and fetches only; stores leave it unchanged), set the owner's gnt, and go to DONE.
- DONE: gnt high for exactly this cycle. `mem_en` and `mem_we` are 0. Requests are ignored. Go to IDLE.
- Requester inputs are not sampled outside IDLE. Changing them mid-access has no effect on the transaction in progress.
- Both `if_gnt` and `d_gnt` are never high in the same cycle.
- `if_rdata` and `d_rdata` hold their last captured value between grants.
- Reset (any cycle, including mid-ACCESS): state returns to IDLE and the access is aborted without a grant.
  - All outputs go to 0: gnts, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, rdata registers, `busy`.
  - `cnt`=0. Round-robin pointer is reset to "D last served", so IF wins the first tie.

## Timing
- Request high in IDLE cycle T gives:
  - ACCESS during cycles T+1 .. T+1+`WAIT_CYCLES`
  - gnt in cycle T+2+`WAIT_CYCLES`
  - IDLE again at T+3+`WAIT_CYCLES`
- Throughput is one transaction per `WAIT_CYCLES`+3 cycles.
- `mem_en` is high for exactly `WAIT_CYCLES`+1 consecutive cycles per transaction.
- A requester that registers its response to gnt presents its next request in the following IDLE cycle. A request still high in IDLE is treated as a new transaction.
- `busy` is registered. It rises in cycle T+1 and falls in the IDLE cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on a simultaneous IF/D request, grant the requester not served last. A lone request is always granted. The pointer updates when the transaction is latched.
- Undefined: fixed priority, D always beats IF. IF can starve while D requests back-to-back; this is the intended behaviour for the in-order core.

## Test plan
- Single fetch, `WAIT_CYCLES`=1: `if_addr`=0x40, `mem_rdata`=0xDEADBEEF. Expect `mem_en` high 2 cycles with `mem_addr`=0x40, `if_gnt` pulse 3 cycles after the request, and `if_rdata`=0xDEADBEEF.
- Store: `d_we`=1, `d_addr`=0x100, `d_wdata`=0x12345678. Expect `mem_we`=1 for the whole ACCESS, one `d_gnt` pulse, and `d_rdata` unchanged.
- Simultaneous requests held continuously. Without the macro: D, D, D, and no `if_gnt`. With the macro: IF, D, IF, D alternating.
- `WAIT_CYCLES`=0 and 15: measure the `mem_en` width (1 / 16 cycles) and the request-to-grant latency (2 / 17 cycles).
- Assert `rst` in the second ACCESS cycle. Expect all outputs 0 immediately, no gnt, IDLE next cycle. A held request after release restarts the full sequence.
- Change `if_addr` mid-ACCESS. Expect `mem_addr` to keep the latched value.
